// File: rtl/rtc_bus_ctrl_pkg.sv
// rtc_bus_pkg: shared types and constants for the RTC multiplexed-bus engine.
package rtc_bus_pkg;

  localparam int RTC_ADDR_W = 7;
  localparam int RTC_DATA_W = 8;

  // Default bus timing, in CLK cycles (each 1..15)
  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_PULSE = 4;
  localparam int DEF_T_HOLD  = 2;
  localparam int DEF_T_GAP   = 4;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    A_SETUP  = 4'd1,
    A_STROBE = 4'd2,
    A_HOLD   = 4'd3,
    GAP      = 4'd4,
    D_SETUP  = 4'd5,
    D_STROBE = 4'd6,
    D_HOLD   = 4'd7,
    DONE     = 4'd8
  } rtc_state_e;

  // Phase counter load value: the counter runs len-1 .. 0, so a phase lasts len cycles
  function automatic logic [3:0] phase_load(input int len);
    return 4'(len - 1);
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// rtc_bus_ctrl_if: request side (upstream FSM) and RTC AD-bus side of the engine.
interface rtc_bus_ctrl_if;
  import rtc_bus_pkg::*;

  logic                  Acceso;
  logic                  Mod;
  logic [RTC_ADDR_W-1:0] Dir;
  logic [RTC_DATA_W-1:0] Wdata;
  logic [RTC_DATA_W-1:0] ad_in;
  logic [RTC_DATA_W-1:0] ad_out;
  logic                  ad_oe;
  logic                  AD_n;
  logic                  CS_n;
  logic                  RD_n;
  logic                  WR_n;
  logic [RTC_DATA_W-1:0] Rdata;
  logic                  FRW;
  logic                  Busy;

  // Requester (sequencing FSM plus pad read-back)
  modport master (
    output Acceso, Mod, Dir, Wdata, ad_in,
    input  ad_out, ad_oe, AD_n, CS_n, RD_n, WR_n, Rdata, FRW, Busy
  );

  // Bus-cycle engine
  modport slave (
    input  Acceso, Mod, Dir, Wdata, ad_in,
    output ad_out, ad_oe, AD_n, CS_n, RD_n, WR_n, Rdata, FRW, Busy
  );

endinterface

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: runs one address phase + data phase on the RTC's Intel-mode
// multiplexed AD bus per Acceso rising edge, then pulses FRW. All bus outputs
// are flops loaded on the edge that enters the state they belong to.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int T_GAP   = DEF_T_GAP
) (
  input  logic           CLK,
  input  logic           RST,
  rtc_bus_ctrl_if.slave  bus
);

  localparam logic [3:0] LD_SETUP = phase_load(T_SETUP);
  localparam logic [3:0] LD_PULSE = phase_load(T_PULSE);
  localparam logic [3:0] LD_HOLD  = phase_load(T_HOLD);
  localparam logic [3:0] LD_GAP   = phase_load(T_GAP);

  rtc_state_e            state_r, state_nxt_s;
  logic [3:0]            cnt_r, cnt_nxt_s;
  logic                  acceso_prev_r;
  logic                  start_s;

  logic [RTC_ADDR_W-1:0] dir_r, dir_nxt_s;
  logic                  mod_r, mod_nxt_s;
  logic [RTC_DATA_W-1:0] wdata_r, wdata_nxt_s;

  logic                  cs_n_r, cs_n_nxt_s;
  logic                  rd_n_r, rd_n_nxt_s;
  logic                  wr_n_r, wr_n_nxt_s;
  logic                  ad_n_r, ad_n_nxt_s;
  logic                  ad_oe_r, ad_oe_nxt_s;
  logic [RTC_DATA_W-1:0] ad_out_r, ad_out_nxt_s;
  logic                  frw_r, frw_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic [RTC_DATA_W-1:0] rdata_r, rdata_nxt_s;

  // Only a fresh rising edge seen while idle starts a transaction
  assign start_s = (state_r == IDLE) && bus.Acceso && !acceso_prev_r;

  // Next state and phase counter: each phase lasts its length, then advances
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s = A_SETUP;
          cnt_nxt_s   = LD_SETUP;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
      default: begin
        if (cnt_r != 4'd0) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          case (state_r)
            A_SETUP:  begin state_nxt_s = A_STROBE; cnt_nxt_s = LD_PULSE; end
            A_STROBE: begin state_nxt_s = A_HOLD;   cnt_nxt_s = LD_HOLD;  end
            A_HOLD:   begin state_nxt_s = GAP;      cnt_nxt_s = LD_GAP;   end
            GAP:      begin state_nxt_s = D_SETUP;  cnt_nxt_s = LD_SETUP; end
            D_SETUP:  begin state_nxt_s = D_STROBE; cnt_nxt_s = LD_PULSE; end
            D_STROBE: begin state_nxt_s = D_HOLD;   cnt_nxt_s = LD_HOLD;  end
            D_HOLD:   begin state_nxt_s = DONE;     cnt_nxt_s = 4'd0;     end
            default:  begin state_nxt_s = IDLE;     cnt_nxt_s = 4'd0;     end
          endcase
        end
      end
    endcase
  end

  // Request capture: Dir/Mod/Wdata frozen at the start edge for the whole transaction
  always_comb begin
    if (start_s) begin
      dir_nxt_s   = bus.Dir;
      mod_nxt_s   = bus.Mod;
      wdata_nxt_s = bus.Wdata;
    end else begin
      dir_nxt_s   = dir_r;
      mod_nxt_s   = mod_r;
      wdata_nxt_s = wdata_r;
    end
  end

  // Bus outputs for the state being entered, using the captured request
  always_comb begin
    cs_n_nxt_s   = 1'b1;
    rd_n_nxt_s   = 1'b1;
    wr_n_nxt_s   = 1'b1;
    ad_n_nxt_s   = 1'b1;
    ad_oe_nxt_s  = 1'b0;
    ad_out_nxt_s = 8'h00;
    frw_nxt_s    = 1'b0;
    busy_nxt_s   = 1'b1;
    case (state_nxt_s)
      A_SETUP, A_STROBE, A_HOLD: begin
        cs_n_nxt_s   = 1'b0;
        ad_n_nxt_s   = 1'b0;
        ad_oe_nxt_s  = 1'b1;
        ad_out_nxt_s = {1'b0, dir_nxt_s};
        wr_n_nxt_s   = (state_nxt_s == A_STROBE) ? 1'b0 : 1'b1;
      end
      GAP: begin
        busy_nxt_s = 1'b1;
      end
      D_SETUP, D_STROBE, D_HOLD: begin
        cs_n_nxt_s   = 1'b0;
        ad_oe_nxt_s  = mod_nxt_s;
        ad_out_nxt_s = mod_nxt_s ? wdata_nxt_s : 8'h00;
        if (state_nxt_s == D_STROBE) begin
          wr_n_nxt_s = !mod_nxt_s;
          rd_n_nxt_s = mod_nxt_s;
        end else begin
          wr_n_nxt_s = 1'b1;
          rd_n_nxt_s = 1'b1;
        end
      end
      DONE: begin
        frw_nxt_s  = 1'b1;
        busy_nxt_s = 1'b0;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Read capture on the edge that leaves D_STROBE, while RD_n is still low
  always_comb begin
    if ((state_r == D_STROBE) && (cnt_r == 4'd0) && !mod_r) begin
      rdata_nxt_s = bus.ad_in;
    end else begin
      rdata_nxt_s = rdata_r;
    end
  end

  // State, counter, captured request and output flops; reset releases the bus at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r       <= IDLE;
      cnt_r         <= 4'd0;
      acceso_prev_r <= 1'b0;
      dir_r         <= 7'h00;
      mod_r         <= 1'b0;
      wdata_r       <= 8'h00;
      cs_n_r        <= 1'b1;
      rd_n_r        <= 1'b1;
      wr_n_r        <= 1'b1;
      ad_n_r        <= 1'b1;
      ad_oe_r       <= 1'b0;
      ad_out_r      <= 8'h00;
      frw_r         <= 1'b0;
      busy_r        <= 1'b0;
      rdata_r       <= 8'h00;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      acceso_prev_r <= bus.Acceso;
      dir_r         <= dir_nxt_s;
      mod_r         <= mod_nxt_s;
      wdata_r       <= wdata_nxt_s;
      cs_n_r        <= cs_n_nxt_s;
      rd_n_r        <= rd_n_nxt_s;
      wr_n_r        <= wr_n_nxt_s;
      ad_n_r        <= ad_n_nxt_s;
      ad_oe_r       <= ad_oe_nxt_s;
      ad_out_r      <= ad_out_nxt_s;
      frw_r         <= frw_nxt_s;
      busy_r        <= busy_nxt_s;
      rdata_r       <= rdata_nxt_s;
    end
  end

  assign bus.CS_n   = cs_n_r;
  assign bus.RD_n   = rd_n_r;
  assign bus.WR_n   = wr_n_r;
  assign bus.AD_n   = ad_n_r;
  assign bus.ad_oe  = ad_oe_r;
  assign bus.ad_out = ad_out_r;
  assign bus.FRW    = frw_r;
  assign bus.Busy   = busy_r;
  assign bus.Rdata  = rdata_r;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: randomized checks of rtc_bus_ctrl (default timing and a
// T_PULSE=1/T_GAP=1 instance) against a cycle-window reference model.
module tb_rtc_bus_ctrl;

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [7:0] rd_model [2];

  always #5 CLK = ~CLK;

  rtc_bus_ctrl_if bus0 ();
  rtc_bus_ctrl_if bus1 ();

  rtc_bus_ctrl dut0 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus0)
  );

  rtc_bus_ctrl #(.T_SETUP(2), .T_PULSE(1), .T_HOLD(2), .T_GAP(1)) dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus1)
  );

  function automatic int tp_of(input int sel);
    return (sel == 0) ? 4 : 1;
  endfunction

  function automatic int tg_of(input int sel);
    return (sel == 0) ? 4 : 1;
  endfunction

  // Observed vector: {CS_n,RD_n,WR_n,AD_n,ad_oe,FRW,Busy,ad_out[7:0],Rdata[7:0]}
  function automatic logic [22:0] obs(input int sel);
    if (sel == 0)
      return {bus0.CS_n, bus0.RD_n, bus0.WR_n, bus0.AD_n, bus0.ad_oe, bus0.FRW, bus0.Busy, bus0.ad_out, bus0.Rdata};
    else
      return {bus1.CS_n, bus1.RD_n, bus1.WR_n, bus1.AD_n, bus1.ad_oe, bus1.FRW, bus1.Busy, bus1.ad_out, bus1.Rdata};
  endfunction

  function automatic logic [22:0] idle_vec(input logic [7:0] rdv);
    return {4'b1111, 3'b000, 8'h00, rdv};
  endfunction

  // Expected bus in the cycle after edge k (start edge = 0), from time windows
  function automatic logic [22:0] exp_vec(input int k, input int ts, input int tp, input int th, input int tg,
                                          input logic m, input logic [6:0] d, input logic [7:0] w,
                                          input logic [7:0] rprev, input logic [7:0] rnew);
    int a1, a2, a3, g, d1, d2, d3;
    logic cs, rd, wr, adn, oe, frw, busy;
    logic [7:0] o, rv;
    a1 = ts; a2 = ts + tp; a3 = ts + tp + th; g = a3 + tg;
    d1 = g + ts; d2 = d1 + tp; d3 = d2 + th;
    cs = 1'b1; rd = 1'b1; wr = 1'b1; adn = 1'b1; oe = 1'b0; frw = 1'b0; busy = 1'b0;
    o = 8'h00; rv = rprev;
    if (k < a3) begin
      cs = 1'b0; adn = 1'b0; oe = 1'b1; o = {1'b0, d}; busy = 1'b1;
      if (k >= a1 && k < a2) wr = 1'b0;
    end else if (k < g) begin
      busy = 1'b1;
    end else if (k < d3) begin
      cs = 1'b0; oe = m; o = m ? w : 8'h00; busy = 1'b1;
      if (k >= d1 && k < d2) begin
        if (m) wr = 1'b0;
        else   rd = 1'b0;
      end
    end else if (k == d3) begin
      frw = 1'b1;
    end
    if (!m && k >= d2) rv = rnew;
    return {cs, rd, wr, adn, oe, frw, busy, o, rv};
  endfunction

  task automatic drive(input int sel, input logic acc, input logic m, input logic [6:0] d,
                       input logic [7:0] w, input logic [7:0] ai);
    if (sel == 0) begin
      bus0.Acceso = acc; bus0.Mod = m; bus0.Dir = d; bus0.Wdata = w; bus0.ad_in = ai;
    end else begin
      bus1.Acceso = acc; bus1.Mod = m; bus1.Dir = d; bus1.Wdata = w; bus1.ad_in = ai;
    end
  endtask

  // One transaction. mode 0: Acceso drops at FRW; 1: Acceso held high long after;
  // 2: extra Acceso rising edge at edge 10. Request inputs are scrambled after the start.
  task automatic run_txn(input int sel, input logic m, input logic [6:0] d, input logic [7:0] w,
                         input logic [7:0] rd, input int mode);
    int ts, tp, th, tg, L, d1, d2, frw_cnt;
    logic acc;
    logic [22:0] e, o;
    logic [7:0] rprev;
    ts = 2; tp = tp_of(sel); th = 2; tg = tg_of(sel);
    L  = 2 * (ts + tp + th) + tg;
    d1 = ts + tp + th + tg + ts;
    d2 = d1 + tp;
    frw_cnt = 0;
    rprev = rd_model[sel];
    drive(sel, 1'b1, m, d, w, 8'($urandom));
    for (int k = 0; k <= L + 1; k++) begin
      @(posedge CLK); #1;
      e = exp_vec(k, ts, tp, th, tg, m, d, w, rprev, rd);
      o = obs(sel);
      n_checks++;
      if (o !== e) begin
        n_errors++;
        $display("FAIL txn dut%0d k=%0d: got %h expected %h", sel, k, o, e);
      end
      if (o[17]) frw_cnt++;
      if (mode == 1)               acc = 1'b1;
      else if (mode == 2 && k == 8) acc = 1'b0;
      else if (k >= L)              acc = 1'b0;
      else                          acc = 1'b1;
      drive(sel, acc, 1'($urandom), 7'($urandom), 8'($urandom),
            (k >= d1 && k < d2) ? rd : 8'($urandom));
    end
    if (!m) rd_model[sel] = rd;
    if (mode == 1) begin
      for (int k = 0; k < 10; k++) begin
        @(posedge CLK); #1;
        o = obs(sel);
        if (o[17]) frw_cnt++;
        n_checks++;
        if (o !== idle_vec(rd_model[sel])) begin
          n_errors++;
          $display("FAIL held_high dut%0d idle k=%0d: got %h expected %h", sel, k, o, idle_vec(rd_model[sel]));
        end
      end
      drive(sel, 1'b0, 1'b0, 7'h00, 8'h00, 8'($urandom));
      @(posedge CLK); #1;
    end
    n_checks++;
    if (frw_cnt != 1) begin
      n_errors++;
      $display("FAIL frw_count dut%0d: got %0d expected 1", sel, frw_cnt);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (obs(s) !== idle_vec(8'h00)) begin
        n_errors++;
        $display("FAIL reset dut%0d: got %h expected %h", s, obs(s), idle_vec(8'h00));
      end
    end
  endtask

  // Acceso already high when reset releases: the first edge is the start
  task automatic test_init_access();
    bus1.Acceso = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    run_txn(1, 1'b0, 7'($urandom), 8'($urandom), 8'($urandom), 0);
  endtask

  task automatic test_write();
    run_txn(0, 1'b1, 7'h21, 8'h5A, 8'($urandom), 0);
    for (int i = 0; i < 2; i++) run_txn(0, 1'b1, 7'($urandom), 8'($urandom), 8'($urandom), 0);
  endtask

  task automatic test_read();
    run_txn(0, 1'b0, 7'h41, 8'hA7, 8'hA7, 0);
    for (int i = 0; i < 2; i++) run_txn(0, 1'b0, 7'($urandom), 8'($urandom), 8'($urandom), 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) run_txn(0, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 0);
  endtask

  task automatic test_held_high();
    run_txn(0, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1);
  endtask

  task automatic test_retrigger();
    run_txn(0, 1'b0, 7'($urandom), 8'($urandom), 8'($urandom), 2);
  endtask

  task automatic test_back_to_back();
    run_txn(0, 1'b0, 7'($urandom), 8'($urandom), 8'($urandom), 0);
    run_txn(0, 1'b1, 7'($urandom), 8'($urandom), 8'($urandom), 0);
    run_txn(0, 1'b0, 7'($urandom), 8'($urandom), 8'($urandom), 0);
  endtask

  task automatic test_mid_reset();
    logic [6:0] d;
    logic [7:0] w;
    logic [22:0] o;
    d = 7'($urandom); w = 8'($urandom);
    drive(0, 1'b1, 1'b1, d, w, 8'($urandom));
    for (int k = 0; k <= 3; k++) begin
      @(posedge CLK); #1;
      n_checks++;
      if (obs(0) !== exp_vec(k, 2, 4, 2, 4, 1'b1, d, w, rd_model[0], 8'h00)) begin
        n_errors++;
        $display("FAIL mid_reset pre k=%0d: got %h expected %h", k, obs(0),
                 exp_vec(k, 2, 4, 2, 4, 1'b1, d, w, rd_model[0], 8'h00));
      end
    end
    #2 RST = 1'b1;
    #1;
    rd_model[0] = 8'h00;
    rd_model[1] = 8'h00;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (obs(s) !== idle_vec(8'h00)) begin
        n_errors++;
        $display("FAIL mid_reset async dut%0d: got %h expected %h", s, obs(s), idle_vec(8'h00));
      end
    end
    drive(0, 1'b0, 1'b0, 7'h00, 8'h00, 8'($urandom));
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge CLK); #1;
      o = obs(0);
      n_checks++;
      if (o !== idle_vec(8'h00)) begin
        n_errors++;
        $display("FAIL mid_reset after k=%0d: got %h expected %h", k, o, idle_vec(8'h00));
      end
    end
    run_txn(0, 1'b0, 7'($urandom), 8'($urandom), 8'($urandom), 0);
  endtask

  task automatic test_param_override();
    run_txn(1, 1'b1, 7'($urandom), 8'($urandom), 8'($urandom), 0);
    run_txn(1, 1'b0, 7'($urandom), 8'($urandom), 8'($urandom), 0);
    for (int i = 0; i < 3; i++) run_txn(1, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 0);
  endtask

  initial begin
    RST = 1'b1;
    rd_model[0] = 8'h00;
    rd_model[1] = 8'h00;
    drive(0, 1'b0, 1'b0, 7'h00, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 7'h00, 8'h00, 8'h00);
    test_reset();
    test_init_access();
    test_write();
    test_read();
    test_random();
    test_held_high();
    test_retrigger();
    test_back_to_back();
    test_mid_reset();
    test_param_override();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
